// File: rtl/jpeg_decoder_axi_pkg.sv
// Shared constants for the decoder AXI write path: FSM encoding, AXI field values
// and the 4KB page helper used when sizing bursts.
package jpeg_decoder_axi_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned PAGE_BYTES    = 4096;

  // Word beats left before the next 4KB page; the address is always word aligned.
  function automatic logic [10:0] beats_to_page_end(input logic [11:0] addr_low);
    logic [12:0] bytes_left;
    bytes_left = 13'(PAGE_BYTES) - {1'b0, addr_low};
    return bytes_left[12:2];
  endfunction

endpackage

// File: rtl/jpeg_decoder_axi_burst_calc.sv
// Combinational burst sizing: the smallest of words remaining, MAX_BURST and the
// beats left before the 4KB page boundary.
module jpeg_decoder_axi_burst_calc
  import jpeg_decoder_axi_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic [23:0] remain,
  input  logic [11:0] addr_low,
  output logic [8:0]  len
);

  logic [23:0] page_beats;
  logic [23:0] max_beats;
  logic [23:0] lim_a;
  logic [23:0] lim_b;

  always_comb begin
    page_beats = {13'd0, beats_to_page_end(addr_low)};
    max_beats  = 24'(MAX_BURST);
    lim_a      = (remain < max_beats) ? remain : max_beats;
    lim_b      = (page_beats < lim_a) ? page_beats : lim_a;
    len        = lim_b[8:0];
  end

endmodule

// File: rtl/jpeg_decoder_axi_writer.sv
// Drains the decoder output FIFO into memory as AXI4 INCR write bursts, one burst
// outstanding at a time, never crossing a 4KB page.
module jpeg_decoder_axi_writer
  import jpeg_decoder_axi_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter logic [3:0]  AXI_ID    = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [23:0] length_i,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_valid_i,
  input  logic [10:0] fifo_level_i,
  output logic        fifo_pop_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awid_o,
  output logic [7:0]  awlen_o,
  output logic [1:0]  awburst_o,
  output logic [2:0]  awsize_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  logic [2:0]  state_reg;
  logic [31:0] addr_reg;
  logic [23:0] remain_reg;
  logic [7:0]  awlen_reg;
  logic [7:0]  beat_reg;
  logic        error_reg;
  logic        done_reg;
  logic [8:0]  calc_len;
  logic [8:0]  burst_len;
  logic        in_data;

  jpeg_decoder_axi_burst_calc #(.MAX_BURST(MAX_BURST)) u_burst_calc (
    .remain   (remain_reg),
    .addr_low (addr_reg[11:0]),
    .len      (calc_len)
  );

  // Beat count is kept as awlen so reset leaves awlen_o at 0 instead of 0xFF.
  assign burst_len = {1'b0, awlen_reg} + 9'd1;
  assign in_data   = (state_reg == ST_DATA);

  assign awvalid_o  = (state_reg == ST_ADDR);
  assign awaddr_o   = addr_reg;
  assign awid_o     = AXI_ID;
  assign awlen_o    = awlen_reg;
  assign awburst_o  = AXI_BURST_INCR;
  assign awsize_o   = AXI_SIZE_4B;
  assign wvalid_o   = in_data & fifo_valid_i;
  assign wdata_o    = in_data ? fifo_data_i : 32'd0;
  assign wstrb_o    = 4'hF;
  assign wlast_o    = in_data && (beat_reg == awlen_reg);
  assign fifo_pop_o = wvalid_o & wready_i;
  assign bready_o   = (state_reg == ST_RESP);
  assign busy_o     = (state_reg != ST_IDLE);
  assign done_o     = done_reg;
  assign error_o    = error_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= 32'd0;
      remain_reg <= 24'd0;
      awlen_reg  <= 8'd0;
      beat_reg   <= 8'd0;
      error_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            addr_reg   <= {base_addr_i[31:2], 2'b00};
            remain_reg <= length_i;
            error_reg  <= 1'b0;
            if (length_i == 24'd0) done_reg <= 1'b1;
            else state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          // Only issue AW once the whole burst is already in the FIFO.
          if ({2'b00, calc_len} <= fifo_level_i) begin
            awlen_reg <= 8'(calc_len - 9'd1);
            beat_reg  <= 8'd0;
            state_reg <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (awready_i) state_reg <= ST_DATA;
        end
        ST_DATA: begin
          if (fifo_pop_o) begin
            beat_reg <= beat_reg + 8'd1;
            if (beat_reg == awlen_reg) state_reg <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bvalid_i) begin
            if (bresp_i != AXI_RESP_OKAY) error_reg <= 1'b1;
            addr_reg   <= addr_reg + {21'd0, burst_len, 2'b00};
            remain_reg <= remain_reg - {15'd0, burst_len};
            if (remain_reg == {15'd0, burst_len}) begin
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_CALC;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
